debounce_bank: RTL

//  N-channel switch/button debouncer with per-channel 2-FF synchroniser, press/release edge pulses
//  and long-press hold detection with optional auto-repeat. Sits between raw board pins (buttons,
//  DIP switches) and user logic (e.g. single-step / reset-request / mode inputs of the RISC-V core).

---
 rtl/debounce_bank_pkg.sv | 33 +++
 rtl/debounce_channel.sv | 121 ++++++++++++
 rtl/debounce_bank.sv | 41 ++++
 3 files changed

// File: rtl/debounce_bank_pkg.sv
// Shared definitions for the debounce bank: hold FSM state encoding and
// counter-width helpers evaluated at elaboration time.
package debounce_bank_pkg;

   typedef enum logic [1:0] {
      HOLD_IDLE   = 2'd0,
      HOLD_WAIT   = 2'd1,
      HOLD_REPEAT = 2'd2
   } hold_state_t;

   function automatic int unsigned clog2(input longint unsigned value);
      int unsigned bits;
      bits = 0;
      for (int unsigned i = 0; i < 63; i++) begin
         if ((64'(1) << i) < value) begin
            bits = i + 1;
         end
      end
      return bits;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Width able to hold the terminal value itself; never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned terminal);
      int unsigned w;
      w = clog2(64'(terminal) + 64'(1));
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchroniser, stable-count debounce, registered
// edge pulses and long-press / auto-repeat hold detection.
module debounce_channel
   import debounce_bank_pkg::*;
#(
   parameter int unsigned DEBOUNCE_LIMIT = 250000,
   parameter int unsigned HOLD_LIMIT     = 12500000,
   parameter int unsigned REPEAT_LIMIT   = 2500000
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall,
   output logic hold
);

   localparam int unsigned DW = cnt_width(DEBOUNCE_LIMIT);
   localparam logic [DW-1:0] DCNT_TERM = DW'(DEBOUNCE_LIMIT - 1);

   logic [1:0]    sync_q;
   logic          s;
   logic [DW-1:0] dcnt;
   logic          flip;
   logic          level_next;

   assign s = sync_q[1];

   always_comb begin
      flip       = (s != level) && (dcnt == DCNT_TERM);
      level_next = flip ? s : level;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         dcnt   <= '0;
         level  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], pin};
         level  <= level_next;
         rise   <= flip & s;
         fall   <= flip & ~s;
         if ((s == level) || flip) begin
            dcnt <= '0;
         end else begin
            dcnt <= dcnt + 1'b1;
         end
      end
   end

   generate
      if (HOLD_LIMIT == 0) begin : g_no_hold
         assign hold = 1'b0;
      end else begin : g_hold
         localparam int unsigned HW = cnt_width(max_u(HOLD_LIMIT, REPEAT_LIMIT));
         localparam logic [HW-1:0] HOLD_TERM = HW'(HOLD_LIMIT);
         localparam logic [HW-1:0] REP_TERM  = HW'(REPEAT_LIMIT);

         hold_state_t   state;
         logic [HW-1:0] hcnt;

         // Driven from level_next so WAIT is entered on the same edge that
         // raises o_Rise, and a release edge suppresses a coincident hold.
         // With REPEAT_LIMIT==0 the REPEAT state simply parks (no more pulses).
         always_ff @(posedge clk) begin
            if (rst) begin
               state <= HOLD_IDLE;
               hcnt  <= '0;
               hold  <= 1'b0;
            end else begin
               hold <= 1'b0;
               if (!level_next) begin
                  state <= HOLD_IDLE;
                  hcnt  <= '0;
               end else begin
                  case (state)
                     HOLD_IDLE: begin
                        state <= HOLD_WAIT;
                        hcnt  <= HW'(1);
                     end
                     HOLD_WAIT: begin
                        if (hcnt == HOLD_TERM) begin
                           hold  <= 1'b1;
                           hcnt  <= HW'(1);
                           state <= HOLD_REPEAT;
                        end else begin
                           hcnt <= hcnt + 1'b1;
                        end
                     end
                     HOLD_REPEAT: begin
                        if (REPEAT_LIMIT != 0) begin
                           if (hcnt == REP_TERM) begin
                              hold <= 1'b1;
                              hcnt <= HW'(1);
                           end else begin
                              hcnt <= hcnt + 1'b1;
                           end
                        end
                     end
                     default: begin
                        state <= HOLD_IDLE;
                        hcnt  <= '0;
                     end
                  endcase
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(rise && fall));
      end
   end

endmodule

// File: rtl/debounce_bank.sv
// N-channel switch/button debouncer: polarity normalisation followed by one
// independent debounce_channel per pin.
module debounce_bank
   import debounce_bank_pkg::*;
#(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned DEBOUNCE_LIMIT = 250000,
   parameter int unsigned HOLD_LIMIT     = 12500000,
   parameter int unsigned REPEAT_LIMIT   = 2500000,
   parameter logic        ACTIVE_LOW     = 1'b1
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic [NUM_CH-1:0] i_Switch,
   output logic [NUM_CH-1:0] o_Level,
   output logic [NUM_CH-1:0] o_Rise,
   output logic [NUM_CH-1:0] o_Fall,
   output logic [NUM_CH-1:0] o_Hold
);

   logic [NUM_CH-1:0] pin;

   assign pin = i_Switch ^ {NUM_CH{ACTIVE_LOW}};

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
         .HOLD_LIMIT     (HOLD_LIMIT),
         .REPEAT_LIMIT   (REPEAT_LIMIT)
      ) u_channel (
         .clk   (i_Clk),
         .rst   (i_Rst),
         .pin   (pin[ch]),
         .level (o_Level[ch]),
         .rise  (o_Rise[ch]),
         .fall  (o_Fall[ch]),
         .hold  (o_Hold[ch])
      );
   end

endmodule
